// File: rtl/stump_pkg.sv
// rtl/stump_pkg.sv - Stump ISA shared definitions: states, opcodes, condition codes, flag bits
package stump_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_MEMORY  = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_LDST = 3'b110;
  localparam logic [2:0] OP_BCC  = 3'b111;

  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_NV = 4'd1;
  localparam logic [3:0] CC_HI = 4'd2;
  localparam logic [3:0] CC_LS = 4'd3;
  localparam logic [3:0] CC_CC = 4'd4;
  localparam logic [3:0] CC_CS = 4'd5;
  localparam logic [3:0] CC_NE = 4'd6;
  localparam logic [3:0] CC_EQ = 4'd7;
  localparam logic [3:0] CC_VC = 4'd8;
  localparam logic [3:0] CC_VS = 4'd9;
  localparam logic [3:0] CC_PL = 4'd10;
  localparam logic [3:0] CC_MI = 4'd11;
  localparam logic [3:0] CC_GE = 4'd12;
  localparam logic [3:0] CC_LT = 4'd13;
  localparam logic [3:0] CC_GT = 4'd14;
  localparam logic [3:0] CC_LE = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam logic [2:0] REG_PC = 3'd7;

endpackage

// File: rtl/stump_cond_eval.sv
// rtl/stump_cond_eval.sv - Bcc condition evaluation against the registered NZVC flags
module stump_cond_eval
  import stump_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, v, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_AL: taken = 1'b1;
      CC_NV: taken = 1'b0;
      CC_HI: taken = !c && !z;
      CC_LS: taken = c || z;
      CC_CC: taken = !c;
      CC_CS: taken = c;
      CC_NE: taken = !z;
      CC_EQ: taken = z;
      CC_VC: taken = !v;
      CC_VS: taken = v;
      CC_PL: taken = !n;
      CC_MI: taken = n;
      CC_GE: taken = (n == v);
      CC_LT: taken = (n != v);
      CC_GT: taken = !z && (n == v);
      CC_LE: taken = z || (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/stump_control.sv
// rtl/stump_control.sv - Stump fetch/execute/memory sequencer with IR, NZVC flags and decode
module stump_control
  import stump_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [3:0]  flags_in,
  output logic [1:0]  state,
  output logic [2:0]  alu_func,
  output logic        c_in,
  output logic [3:0]  flags,
  output logic [15:0] ir,
  output logic        reg_write,
  output logic [2:0]  dest,
  output logic [2:0]  src_a,
  output logic [2:0]  src_b,
  output logic [1:0]  shift_op,
  output logic        imm_sel,
  output logic        imm_kind,
  output logic        addr_sel,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic        pc_inc
);

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [3:0]  flags_q;
  logic        ir_we, flags_we, taken;
  logic [2:0]  op;
  logic        ir_type;
  logic [1:0]  alu_shift;

  assign op        = ir_q[15:13];
  assign ir_type   = ir_q[12];
  assign alu_shift = ir_type ? 2'b00 : ir_q[1:0];

  stump_cond_eval u_cond_eval (
    .cond  (ir_q[11:8]),
    .flags (flags_q),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= 16'h0000;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (ir_we)    ir_q    <= mem_rdata;
      if (flags_we) flags_q <= flags_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_we     = 1'b0;
    flags_we  = 1'b0;
    alu_func  = OP_ADD;
    reg_write = 1'b0;
    dest      = ir_q[10:8];
    src_a     = ir_q[7:5];
    src_b     = ir_q[4:2];
    shift_op  = 2'b00;
    imm_sel   = 1'b0;
    imm_kind  = 1'b0;
    addr_sel  = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    pc_inc    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_ren = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        case (op)
          OP_LDST: begin
            imm_sel  = ir_type;
            shift_op = alu_shift;
            state_d  = ST_MEMORY;
          end
          OP_BCC: begin
            src_a     = REG_PC;
            dest      = REG_PC;
            imm_sel   = 1'b1;
            imm_kind  = 1'b1;
            reg_write = taken;
          end
          default: begin
            alu_func  = op;
            imm_sel   = ir_type;
            shift_op  = alu_shift;
            reg_write = 1'b1;
            flags_we  = ir_q[11];
          end
        endcase
      end
      ST_MEMORY: begin
        // Keep the address-add operands stable so the ALU result still addresses memory.
        addr_sel = 1'b1;
        imm_sel  = ir_type;
        shift_op = alu_shift;
        if (ir_q[11]) begin
          mem_wen = 1'b1;
          src_b   = ir_q[10:8];
        end else begin
          mem_ren   = 1'b1;
          reg_write = mem_ready;
        end
        if (mem_ready) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign state = state_q;
  assign ir    = ir_q;
  assign flags = flags_q;
  assign c_in  = flags_q[FLAG_C];

endmodule

// File: doc/stump_control.md
# stump_control

Instruction-sequencing controller for the Stump datapath. It holds the three-state fetch/execute/memory machine, the instruction register and the NZVC flag register, and decodes each instruction into ALU function, register-file, operand-mux and memory strobes. It is the consumer end of the ALU interface: it drives `func` and `c_in` into the ALU and registers the `flags_out` the ALU returns. It sits between memory/register bank and the ALU in the Stump top level.

## Interface
- No parameters; widths are fixed by the Stump ISA (16-bit instruction, 3-bit register index, 4-bit flags).
- One clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_rdata` in 16: instruction word from memory, sampled in FETCH.
- `mem_ready` in 1: memory handshake; FETCH and MEMORY complete only in a cycle where it is 1.
- `flags_in` in 4: ALU `flags_out` {N,Z,V,C}.
- `state` out 2: 00 FETCH, 01 EXECUTE, 10 MEMORY.
- `alu_func` out 3: ALU function code.
- `c_in` out 1: carry into ALU, equals registered C flag.
- `flags` out 4: registered {N,Z,V,C}.
- `ir` out 16: instruction register.
- `reg_write` out 1: register-file write enable.
- `dest`, `src_a`, `src_b` out 3 each: register indices.
- `shift_op` out 2: shifter control.
- `imm_sel` out 1: operand B from immediate.
- `imm_kind` out 1: 0 = sign-extend ir[4:0]; 1 = sign-extend ir[7:0].
- `addr_sel` out 1: 0 = PC drives memory address, 1 = ALU result.
- `mem_ren`, `mem_wen` out 1: memory strobes.
- `pc_inc` out 1: increment PC.

## Operation
- Fields: op=ir[15:13], type=ir[12], S=ir[11], dest=ir[10:8], srcA=ir[7:5], srcB=ir[4:2], shift=ir[1:0]; Bcc cond=ir[11:8].
- FETCH: addr_sel=0, mem_ren=1. When mem_ready: ir<=mem_rdata, pc_inc=1, go EXECUTE; else hold, all strobes unchanged.
- EXECUTE, op 000–101: alu_func=op, imm_sel=type, imm_kind=0, reg_write=1, dest=ir[10:8]; if S=1, flags<=flags_in at cycle end. shift_op=ir[1:0] when type=0, else 00. Next FETCH.
- EXECUTE, op 110 (LD/ST): alu_func=000 (address add), no flag update, reg_write=0. Next MEMORY.
- EXECUTE, op 111 (Bcc): alu_func=000, src_a=7, imm_sel=1, imm_kind=1, dest=7; reg_write=1 only if condition true. Flags never updated. Next FETCH.
- Conditions 0..15: AL, NV, HI(!C&!Z), LS(C|Z), CC(!C), CS(C), NE(!Z), EQ(Z), VC(!V), VS(V), PL(!N), MI(N), GE(N==V), LT(N!=V), GT(!Z&(N==V)), LE(Z|(N!=V)).
- MEMORY: addr_sel=1. ir[11]=0 load: mem_ren=1, reg_write=1 in the mem_ready cycle only. ir[11]=1 store: mem_wen=1, src_b driven to ir[10:8] as store-data read port. Wait while mem_ready=0; go FETCH when 1.
- Outputs are combinational from state and ir; only state, ir, flags are registered.
- c_in always equals flags[0], including ADC/SBC in the same cycle flags are being rewritten (old C used).

## Timing
- Reset (asynchronous, any state): state=FETCH, ir=16'h0000, flags=4'b0000; strobes follow FETCH decode (mem_ren=1, all others 0). First fetch on first rising edge after deassertion with mem_ready=1.
- ALU/branch instruction: 2 cycles minimum; LD/ST: 3 cycles minimum; each mem_ready=0 cycle adds one.
- Flag update visible on `flags` the cycle after EXECUTE.
- Undefined state encoding 11 recovers to FETCH next edge, no strobes asserted.
- mem_ready is ignored in EXECUTE.

## Structure
- Shared package/include: state encodings, opcode constants (ADD…BCC), condition-code constants, flag bit indices; reuse existing Stump definitions file where names already exist.
- One sub-module natural: `stump_cond_eval` (cond[3:0], flags[3:0] → taken), purely combinational.

## Test plan
- Reset mid-MEMORY with rst_n low → state=00, flags=0000, ir=0000 immediately, without waiting for clk.
- Fetch 16'h094C (ADDS R1,R2,R3), flags_in=4'b0101 → EXECUTE: alu_func=000, dest=1, src_a=2, src_b=3, reg_write=1; next cycle flags=0101, state FETCH.
- Fetch 16'hF705 (BEQ +5) with flags Z=1 → reg_write=1, dest=7, imm_kind=1; repeat with Z=0 → reg_write=0; flags unchanged either way.
- Fetch 16'hD223 (LD R2,[R1,#3]) with mem_ready low 2 cycles in MEMORY → state holds 10, reg_write only in the mem_ready=1 cycle, total 5 cycles.
- Fetch 16'hDA23 (ST) → MEMORY: mem_wen=1, mem_ren=0, reg_write=0, src_b=2.
- Sweep all 16 conditions × 16 flag values → reg_write matches the condition table.
